// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: raster geometry, address/colour types and the
// rectangle command record used by the writer and the screen drivers.
package fb_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 4;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef logic [DATA_W-1:0] color_t;
  typedef logic [X_W-1:0]    coord_x_t;
  typedef logic [Y_W-1:0]    coord_y_t;

  typedef struct packed {
    coord_x_t x;
    coord_y_t y;
    coord_x_t w;
    coord_y_t h;
    color_t   color;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fb_state_t;

  localparam fb_addr_t ROW_STRIDE = fb_addr_t'(H_RES);

  // 640 = 512 + 128, so the common case needs only two shifts and an add.
  function automatic fb_addr_t row_base_f(input coord_y_t y);
    fb_addr_t yy;
    yy = fb_addr_t'(y);
    if (H_RES == 640) begin
      return (yy << 9) + (yy << 7);
    end else begin
      return yy * ROW_STRIDE;
    end
  endfunction

endpackage

// File: rtl/framebuffer_writer_if.sv
// Command handshake and RAM write-port bundle for the framebuffer writer.
interface framebuffer_writer_if;
  import fb_pkg::*;

  logic     cmd_valid;
  logic     cmd_ready;
  coord_x_t cmd_x;
  coord_y_t cmd_y;
  coord_x_t cmd_w;
  coord_y_t cmd_h;
  color_t   cmd_color;
  logic     busy;
  logic     done;
  logic     wr_en;
  fb_addr_t wr_addr;
  color_t   wr_data;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, done, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Raster address datapath: row base, current address and column/row counters.
// addr_nxt is the address the datapath moves to on this edge (load or step).
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     load,
  input  logic     step,
  input  coord_x_t x,
  input  coord_y_t y,
  input  coord_x_t w,
  input  coord_y_t h,
  output fb_addr_t addr_nxt,
  output logic     last_col,
  output logic     last_write
);

  fb_addr_t row_base_r;
  fb_addr_t addr_r;
  coord_x_t x_r;
  coord_x_t w_r;
  coord_x_t col_cnt_r;
  coord_y_t row_cnt_r;

  fb_addr_t row_base_nxt_s;
  fb_addr_t addr_nxt_s;
  coord_x_t col_cnt_nxt_s;
  coord_y_t row_cnt_nxt_s;

  assign last_col   = (col_cnt_r == 10'd1);
  assign last_write = last_col && (row_cnt_r == 9'd1);
  assign addr_nxt   = addr_nxt_s;

  // Next-value selection for load, in-row step and row wrap.
  always_comb begin
    row_base_nxt_s = row_base_r;
    addr_nxt_s     = addr_r;
    col_cnt_nxt_s  = col_cnt_r;
    row_cnt_nxt_s  = row_cnt_r;
    if (load) begin
      row_base_nxt_s = row_base_f(y);
      addr_nxt_s     = row_base_f(y) + fb_addr_t'(x);
      col_cnt_nxt_s  = w;
      row_cnt_nxt_s  = h;
    end else if (step) begin
      if (last_col) begin
        row_base_nxt_s = row_base_r + ROW_STRIDE;
        addr_nxt_s     = row_base_r + ROW_STRIDE + fb_addr_t'(x_r);
        col_cnt_nxt_s  = w_r;
        row_cnt_nxt_s  = row_cnt_r - 9'd1;
      end else begin
        addr_nxt_s    = addr_r + fb_addr_t'(1'b1);
        col_cnt_nxt_s = col_cnt_r - 10'd1;
      end
    end else begin
      addr_nxt_s = addr_r;
    end
  end

  // Datapath registers; x and w are kept for the per-row reload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_base_r <= {ADDR_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      x_r        <= 10'd0;
      w_r        <= 10'd0;
      col_cnt_r  <= 10'd0;
      row_cnt_r  <= 9'd0;
    end else begin
      row_base_r <= row_base_nxt_s;
      addr_r     <= addr_nxt_s;
      col_cnt_r  <= col_cnt_nxt_s;
      row_cnt_r  <= row_cnt_nxt_s;
      if (load) begin
        x_r <= x;
        w_r <= w;
      end
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Rectangle-fill write engine for the 4bpp framebuffer RAM, one write per cycle.
// Optional macro FB_WRITER_CLIP_EN clips rectangles to the visible screen.
module framebuffer_writer
  import fb_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  framebuffer_writer_if.slave fb
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);

  fb_state_t state_r;
  fb_state_t state_s;
  rect_cmd_t cmd_r;
  logic      cmd_ready_r;
  logic      busy_r;
  logic      done_r;
  logic      wr_en_r;
  fb_addr_t  wr_addr_r;
  color_t    wr_data_r;

  logic      accept_s;
  logic      load_s;
  logic      step_s;
  coord_x_t  eff_w_s;
  coord_y_t  eff_h_s;
  fb_addr_t  addr_nxt_s;
  logic      last_col_s;
  logic      last_write_s;
  rect_cmd_t cmd_in_s;

  assign fb.cmd_ready = cmd_ready_r;
  assign fb.busy      = busy_r;
  assign fb.done      = done_r;
  assign fb.wr_en     = wr_en_r;
  assign fb.wr_addr   = wr_addr_r;
  assign fb.wr_data   = wr_data_r;

  assign accept_s = (state_r == ST_IDLE) && fb.cmd_valid;
  assign cmd_in_s = '{x: fb.cmd_x, y: fb.cmd_y, w: fb.cmd_w, h: fb.cmd_h, color: fb.cmd_color};

  // Effective rectangle size used by SETUP.
  always_comb begin
    eff_w_s = cmd_r.w;
    eff_h_s = cmd_r.h;
`ifdef FB_WRITER_CLIP_EN
    if ({1'b0, cmd_r.x} >= H_LIM) begin
      eff_w_s = 10'd0;
    end else if ({1'b0, cmd_r.w} > (H_LIM - {1'b0, cmd_r.x})) begin
      eff_w_s = 10'(H_LIM - {1'b0, cmd_r.x});
    end else begin
      eff_w_s = cmd_r.w;
    end
    if ({1'b0, cmd_r.y} >= V_LIM) begin
      eff_h_s = 9'd0;
    end else if ({1'b0, cmd_r.h} > (V_LIM - {1'b0, cmd_r.y})) begin
      eff_h_s = 9'(V_LIM - {1'b0, cmd_r.y});
    end else begin
      eff_h_s = cmd_r.h;
    end
`endif
  end

  fb_addr_gen u_addr_gen (
    .clock      (clock),
    .reset      (reset),
    .load       (load_s),
    .step       (step_s),
    .x          (cmd_r.x),
    .y          (cmd_r.y),
    .w          (eff_w_s),
    .h          (eff_h_s),
    .addr_nxt   (addr_nxt_s),
    .last_col   (last_col_s),
    .last_write (last_write_s)
  );

  // Next-state logic and datapath control.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fb.cmd_valid) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        load_s = 1'b1;
        if ((eff_w_s == 10'd0) || (eff_h_s == 9'd0)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_FILL: begin
        step_s = 1'b1;
        if (last_write_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, command latch and registered outputs decoded from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cmd_r       <= {$bits(rect_cmd_t){1'b0}};
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= (state_s == ST_DONE);
      wr_en_r     <= (state_s == ST_FILL);
      if (accept_s) begin
        cmd_r <= cmd_in_s;
      end
      if (state_s == ST_FILL) begin
        wr_addr_r <= addr_nxt_s;
        wr_data_r <= cmd_r.color;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer: directed and random rectangle fills
// compared against an arithmetic raster model (honours FB_WRITER_CLIP_EN).
module tb_framebuffer_writer;
  import fb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  framebuffer_writer_if fb();

  framebuffer_writer dut (
    .clock (clock),
    .reset (reset),
    .fb    (fb)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  fb_addr_t w_addr_q[$];
  color_t   w_data_q[$];
  int       w_cyc_q[$];
  logic     w_busy_q[$];
  int       done_cyc_q[$];

  always @(negedge clock) begin
    if (fb.wr_en === 1'b1) begin
      w_addr_q.push_back(fb.wr_addr);
      w_data_q.push_back(fb.wr_data);
      w_cyc_q.push_back(cyc);
      w_busy_q.push_back(fb.busy);
    end
    if (fb.done === 1'b1) done_cyc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_w(input int x, input int w);
`ifdef FB_WRITER_CLIP_EN
    if (x >= H_RES) return 0;
    return (w < H_RES - x) ? w : H_RES - x;
`else
    return w;
`endif
  endfunction

  function automatic int eff_h(input int y, input int h);
`ifdef FB_WRITER_CLIP_EN
    if (y >= V_RES) return 0;
    return (h < V_RES - y) ? h : V_RES - y;
`else
    return h;
`endif
  endfunction

  function automatic int exp_addr(input int x, input int y, input int w, input int k);
    int r, c;
    r = k / w;
    c = k % w;
    return ((y + r) * H_RES + x + c) % (1 << ADDR_W);
  endfunction

  task automatic clear_q();
    w_addr_q.delete(); w_data_q.delete(); w_cyc_q.delete(); w_busy_q.delete(); done_cyc_q.delete();
  endtask

  task automatic drive(input int x, input int y, input int w, input int h, input int c);
    fb.cmd_x = 10'(x); fb.cmd_y = 9'(y); fb.cmd_w = 10'(w); fb.cmd_h = 9'(h); fb.cmd_color = 4'(c);
    fb.cmd_valid = 1'b1;
  endtask

  // Present a command and return the cycle stamp of the accepting edge.
  task automatic issue(input int x, input int y, input int w, input int h, input int c, output int acc);
    int n;
    @(negedge clock);
    drive(x, y, w, h, c);
    n = 0;
    while (fb.cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("cmd_ready_wait", fb.cmd_ready, 1'b1);
    @(posedge clock);
    #1;
    acc = cyc;
    fb.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int count, input int budget);
    int n;
    n = 0;
    while (done_cyc_q.size() < count && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("done_seen", done_cyc_q.size(), count);
  endtask

  // Compare the writes starting at base and the didx-th done pulse to the model.
  task automatic check_cmd(input int x, input int y, input int w, input int h, input int c,
                           input int acc, input int base, input int didx);
    int ew, eh, n;
    ew = eff_w(x, w);
    eh = eff_h(y, h);
    n  = ew * eh;
    for (int k = 0; k < n; k++) begin
      if (base + k >= w_addr_q.size()) begin
        chk("write_missing", w_addr_q.size(), base + n);
        break;
      end
      chk("wr_addr", w_addr_q[base+k], exp_addr(x, y, ew, k));
      chk("wr_data", w_data_q[base+k], c);
      chk("wr_cycle", w_cyc_q[base+k], acc + 1 + k);
      chk("busy_in_fill", w_busy_q[base+k], 1'b1);
    end
    if (didx < done_cyc_q.size()) chk("done_cycle", done_cyc_q[didx], acc + 1 + n);
    else chk("done_missing", done_cyc_q.size(), didx + 1);
  endtask

  task automatic run_one(input int x, input int y, input int w, input int h, input int c);
    int acc, n;
    clear_q();
    n = eff_w(x, w) * eff_h(y, h);
    issue(x, y, w, h, c, acc);
    wait_done(1, n + 20);
    chk("write_count", w_addr_q.size(), n);
    check_cmd(x, y, w, h, c, acc, 0, 0);
    @(negedge clock);
    #1;
    chk("ready_after_done", fb.cmd_ready, 1'b1);
    chk("busy_after_done", fb.busy, 1'b0);
  endtask

  initial begin
    int acc_a, acc_b, n, n_b;
    int rx, ry, rw, rh, rc;
    fb.cmd_valid = 1'b0;
    drive(0, 0, 0, 0, 0);
    fb.cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ready", fb.cmd_ready, 1'b1);
    chk("rst_busy", fb.busy, 1'b0);
    chk("rst_done", fb.done, 1'b0);
    chk("rst_wr_en", fb.wr_en, 1'b0);
    chk("rst_wr_addr", fb.wr_addr, 0);
    chk("rst_wr_data", fb.wr_data, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    run_one(10, 5, 3, 2, 7);
    run_one(639, 479, 1, 1, 15);
    run_one(0, 0, 640, 3, 0);
    run_one(3, 100, 0, 5, 4);
    run_one(3, 100, 6, 0, 4);
`ifdef FB_WRITER_CLIP_EN
    run_one(630, 470, 20, 20, 9);
    run_one(700, 0, 5, 5, 3);
    run_one(5, 479, 4, 3, 2);
`else
    run_one(638, 2, 4, 2, 5);
    run_one(1000, 511, 30, 2, 1);
`endif

    // A second command held valid during a fill is taken only after done.
    clear_q();
    issue(20, 30, 4, 2, 6, acc_a);
    drive(50, 60, 3, 3, 11);
    wait_done(1, 40);
    n = 0;
    while (fb.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    acc_b = cyc;
    fb.cmd_valid = 1'b0;
    if (done_cyc_q.size() > 0) chk("held_accept_cycle", acc_b, done_cyc_q[0] + 2);
    wait_done(2, 40);
    n_b = eff_w(50, 3) * eff_h(60, 3);
    chk("held_write_count", w_addr_q.size(), 8 + n_b);
    check_cmd(20, 30, 4, 2, 6, acc_a, 0, 0);
    check_cmd(50, 60, 3, 3, 11, acc_b, 8, 1);

    // Reset during the fourth write of a 10x10 fill.
    clear_q();
    issue(100, 50, 10, 10, 12, acc_a);
    n = 0;
    while (w_addr_q.size() < 4 && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("pre_reset_writes", w_addr_q.size(), 4);
    reset = 1'b1;
    #1;
    chk("async_wr_en", fb.wr_en, 1'b0);
    chk("async_busy", fb.busy, 1'b0);
    chk("async_ready", fb.cmd_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    chk("post_reset_writes", w_addr_q.size(), 4);
    chk("post_reset_done", done_cyc_q.size(), 0);
    run_one(7, 8, 2, 2, 1);

    for (int i = 0; i < 10; i++) begin
      rx = $urandom_range(0, 1023);
      ry = $urandom_range(0, 511);
      rw = $urandom_range(0, 12);
      rh = $urandom_range(0, 5);
      rc = $urandom_range(0, 15);
      run_one(rx, ry, rw, rh, rc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
